// File: rtl/i2s_pkg.sv
// Shared I2S definitions for i2s_rx and i2s_tx: frame geometry, channel codes, slot-to-bit mapping.
// Latency and backpressure: not applicable (package).
package i2s_pkg;
    localparam int   DEF_SAMPLE_BITS = 16;
    localparam int   SLOTS_PER_FRAME = 2 * DEF_SAMPLE_BITS;
    localparam logic LR_LEFT         = 1'b0;
    localparam logic LR_RIGHT        = 1'b1;

    typedef struct packed {
        logic       chan;
        logic [7:0] bit_idx;
    } slot_map_t;

    // One-bit I2S delay: slot 0 still carries the previous frame's right LSB.
    function automatic slot_map_t slot_map(input int slot, input int slots = SLOTS_PER_FRAME);
        slot_map_t m;
        int half;
        half      = slots / 2;
        m.chan    = LR_RIGHT;
        m.bit_idx = 8'd0;
        if (slot >= 1 && slot <= half) begin
            m.chan    = LR_LEFT;
            m.bit_idx = 8'(half - slot);
        end else if (slot > half) begin
            m.bit_idx = 8'(slots - slot);
        end
        return m;
    endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCLK generator with rise/fall/capture strobes; strobes are combinational from the counters.
// No backpressure: counters free-run while enable is high and sit at zero otherwise.
module i2s_clkgen import i2s_pkg::*; #(
    parameter int BCLK_DIV    = 17,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int SLOT_W      = $clog2(2 * SAMPLE_BITS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    output logic              BCLK,
    output logic              LRCLK,
    output logic [SLOT_W-1:0] slot,
    output logic              rise,
    output logic              fall,
    output logic              capture
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int HALF  = BCLK_DIV / 2;
    localparam int SLOTS = 2 * SAMPLE_BITS;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    logic [SLOT_W-1:0] slot_nxt;
    logic              wrap;

    assign wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));

    always_comb begin
        div_nxt  = wrap ? '0 : div_cnt + 1'b1;
        slot_nxt = slot;
        if (wrap) begin
            slot_nxt = (slot == SLOT_W'(SLOTS - 1)) ? '0 : slot + 1'b1;
        end
    end

    // BCLK/LRCLK are registered from the next-state values so they toggle glitch-free with the counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            slot    <= '0;
            BCLK    <= 1'b0;
            LRCLK   <= LR_LEFT;
        end else if (!enable) begin
            div_cnt <= '0;
            slot    <= '0;
            BCLK    <= 1'b0;
            LRCLK   <= LR_LEFT;
        end else begin
            div_cnt <= div_nxt;
            slot    <= slot_nxt;
            BCLK    <= (div_nxt >= DIV_W'(HALF));
            LRCLK   <= (slot_nxt >= SLOT_W'(SAMPLE_BITS)) ? LR_RIGHT : LR_LEFT;
        end
    end

    assign rise    = enable && (div_cnt == DIV_W'(HALF));
    assign fall    = enable && wrap;
    assign capture = enable && (div_cnt == DIV_W'(HALF + 2));
endmodule

// File: rtl/i2s_rx.sv
// I2S master receiver: drives BCLK/LRCLK, deserialises DATA, one stereo pair + FIFO write per frame.
// Latency: outputs update 1 clk after the slot-0 capture; fifo_full drops the write and sets sticky overflow.
module i2s_rx import i2s_pkg::*; #(
    parameter int BCLK_DIV    = 17,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int OUT_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   DATA,
    output logic                   BCLK,
    output logic                   LRCLK,
    output logic [SAMPLE_BITS-1:0] sample_l,
    output logic [SAMPLE_BITS-1:0] sample_r,
    output logic                   sample_valid,
    output logic                   fifo_wr_en,
    output logic [OUT_BITS-1:0]    fifo_wr_data,
    input  logic                   fifo_full,
    output logic                   overflow,
    input  logic                   clear_ovf
);
    localparam int SLOT_W = $clog2(2 * SAMPLE_BITS);

    logic [SLOT_W-1:0]      slot;
    logic                   rise;
    logic                   fall;
    logic                   capture;
    logic [1:0]             data_sync;
    logic [SAMPLE_BITS-1:0] shreg;
    logic [SAMPLE_BITS-1:0] held_l;
    logic [SAMPLE_BITS-1:0] word;
    logic [1:0]             warm;
    logic                   done_l;
    logic                   done_r;
    logic                   unused_rise;
    slot_map_t              map;

    i2s_clkgen #(
        .BCLK_DIV   (BCLK_DIV),
        .SAMPLE_BITS(SAMPLE_BITS),
        .SLOT_W     (SLOT_W)
    ) u_clkgen (
        .clk    (clk),
        .rstn   (rstn),
        .enable (enable),
        .BCLK   (BCLK),
        .LRCLK  (LRCLK),
        .slot   (slot),
        .rise   (rise),
        .fall   (fall),
        .capture(capture)
    );

    // The receive path samples two clk after rise instead, to cover the synchroniser delay.
    assign unused_rise = rise;

    assign map    = slot_map(int'(slot), 2 * SAMPLE_BITS);
    assign word   = {shreg[SAMPLE_BITS-2:0], data_sync[1]};
    assign done_l = capture && (map.chan == LR_LEFT)  && (map.bit_idx == 8'd0);
    assign done_r = capture && (map.chan == LR_RIGHT) && (map.bit_idx == 8'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_sync    <= '0;
            shreg        <= '0;
            held_l       <= '0;
            warm         <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            overflow     <= 1'b0;
        end else begin
            data_sync    <= {data_sync[0], DATA};
            sample_valid <= 1'b0;
            fifo_wr_en   <= 1'b0;
            if (clear_ovf) begin
                overflow <= 1'b0;
            end
            if (!enable) begin
                shreg <= '0;
                warm  <= '0;
            end else begin
                // Outputs start only after two whole frames of LRCLK, so the ADC has locked to word select.
                if (fall && (slot == SLOT_W'(2 * SAMPLE_BITS - 1)) && (warm != 2'd2)) begin
                    warm <= warm + 2'd1;
                end
                if (capture) begin
                    shreg <= word;
                end
                if (done_l) begin
                    held_l <= word;
                end
                if (done_r && (warm == 2'd2)) begin
                    sample_l     <= held_l;
                    sample_r     <= word;
                    sample_valid <= 1'b1;
                    if (fifo_full) begin
                        overflow <= 1'b1;
                    end else begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= held_l[SAMPLE_BITS-1 -: OUT_BITS];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: an I2S ADC model drives DATA; a scoreboard queue holds expected outputs per sample_valid.
module tb_i2s_rx;
    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        DATA;
    logic        BCLK;
    logic        LRCLK;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        overflow;
    logic        clear_ovf;

    always #5 clk = ~clk;

    i2s_rx dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .DATA        (DATA),
        .BCLK        (BCLK),
        .LRCLK       (LRCLK),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        wr;
        logic [7:0]  d;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_l;
    logic [15:0] m_r;
    int          m_slot;
    logic        m_bclk_q;
    int          cyc = 0;
    int          pulse_seen = 0;
    int          unexp = 0;
    int          stray = 0;
    int          run = 0;
    int          last_hi = 0;
    int          last_lo = 0;
    int          lr_rise_prev = -1;
    int          lr_per = 0;
    int          bclk_hi_cnt = 0;
    logic        bclk_prev = 1'b0;
    logic        lr_prev = 1'b0;

    function automatic logic model_bit(input int s);
        if (s == 0) return m_r[0];
        else if (s <= 16) return m_l[16 - s];
        else return m_r[32 - s];
    endfunction

    // External ADC: next bit presented after each BCLK fall, one-bit delayed after word select.
    initial begin
        m_slot   = 0;
        m_bclk_q = 1'b0;
        DATA     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn || !enable) m_slot = 0;
            else if (m_bclk_q && !BCLK) m_slot = (m_slot + 1) % 32;
            m_bclk_q = BCLK;
            DATA = model_bit(m_slot);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        pulse_seen = 0;
        if (sample_valid) begin
            pulse_seen = 1;
            if (sb.size() == 0) begin
                unexp++;
            end else begin
                e = sb.pop_front();
                chk("sample_l", 32'(sample_l), 32'(e.l));
                chk("sample_r", 32'(sample_r), 32'(e.r));
                chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wr));
                if (e.wr) chk("fifo_wr_data", 32'(fifo_wr_data), 32'(e.d));
            end
        end else if (fifo_wr_en) begin
            stray++;
        end
        if (BCLK) bclk_hi_cnt++;
        if (BCLK !== bclk_prev) begin
            if (bclk_prev) last_hi = run;
            else last_lo = run;
            run = 0;
        end
        run++;
        bclk_prev = BCLK;
        if (LRCLK && !lr_prev) begin
            if (lr_rise_prev >= 0) lr_per = cyc - lr_rise_prev;
            lr_rise_prev = cyc;
        end
        lr_prev = LRCLK;
    endtask

    task automatic wait_pulse(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pulse_seen && n < budget);
        chk("pulse_seen", 32'(pulse_seen), 32'd1);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, input logic wr, input logic [7:0] d);
        exp_t e;
        e.l = l; e.r = r; e.wr = wr; e.d = d;
        sb.push_back(e);
    endtask

    initial begin
        int n;
        rstn = 1'b0; enable = 1'b1; fifo_full = 1'b0; clear_ovf = 1'b0;
        m_l = 16'hA55A; m_r = 16'h1234;

        repeat (40) step();
        chk("rst_bclk_static", 32'(bclk_hi_cnt), 32'd0);
        chk("rst_lrclk", 32'(LRCLK), 32'd0);
        chk("rst_sample_l", 32'(sample_l), 32'd0);
        chk("rst_sample_r", 32'(sample_r), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        rstn = 1'b1;
        repeat (3) push(16'hA55A, 16'h1234, 1'b1, 8'hA5);
        wait_pulse(1300, n);
        chk("startup_cycles", 32'(n), 32'd1099);
        wait_pulse(700, n);
        chk("frame_period_1", 32'(n), 32'd544);
        wait_pulse(700, n);
        chk("frame_period_2", 32'(n), 32'd544);
        chk("bclk_high_cycles", 32'(last_hi), 32'd9);
        chk("bclk_low_cycles", 32'(last_lo), 32'd8);
        chk("lrclk_period", 32'(lr_per), 32'd544);

        repeat (300) step();
        fifo_full = 1'b1;
        push(16'hA55A, 16'h1234, 1'b0, 8'h00);
        wait_pulse(700, n);
        chk("ovf_set", 32'(overflow), 32'd1);
        fifo_full = 1'b0;
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        clear_ovf = 1'b1;
        fifo_full = 1'b1;
        push(16'hA55A, 16'h1234, 1'b0, 8'h00);
        wait_pulse(700, n);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        fifo_full = 1'b0;
        step();
        clear_ovf = 1'b0;
        chk("ovf_clear_held", 32'(overflow), 32'd0);

        repeat (340) step();
        chk("pre_dis_bclk", 32'(BCLK), 32'd1);
        chk("pre_dis_lrclk", 32'(LRCLK), 32'd1);
        enable = 1'b0;
        step();
        chk("dis_bclk", 32'(BCLK), 32'd0);
        chk("dis_lrclk", 32'(LRCLK), 32'd0);
        chk("dis_sample_l", 32'(sample_l), 32'h0000A55A);
        chk("dis_sample_r", 32'(sample_r), 32'h00001234);
        bclk_hi_cnt = 0;
        repeat (1200) step();
        chk("idle_bclk", 32'(bclk_hi_cnt), 32'd0);

        enable = 1'b1;
        push(16'hA55A, 16'h1234, 1'b1, 8'hA5);
        wait_pulse(1300, n);
        chk("reenable_cycles", 32'(n), 32'd1099);

        repeat (86) step();
        chk("pre_rst_bclk", 32'(BCLK), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_bclk", 32'(BCLK), 32'd0);
        chk("arst_lrclk", 32'(LRCLK), 32'd0);
        chk("arst_sample_l", 32'(sample_l), 32'd0);
        chk("arst_sample_r", 32'(sample_r), 32'd0);
        chk("arst_wr_data", 32'(fifo_wr_data), 32'd0);
        m_l = 16'h8000; m_r = 16'h7FFF;
        step();
        rstn = 1'b1;
        repeat (2) push(16'h8000, 16'h7FFF, 1'b1, 8'h80);
        wait_pulse(1300, n);
        chk("restart_cycles", 32'(n), 32'd1099);
        wait_pulse(700, n);

        chk("unexpected_pulses", 32'(unexp), 32'd0);
        chk("stray_wr_en", 32'(stray), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
